// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder: word RAM, TOHOST/STATUS MMIO, store-log FIFO
//
// Purpose:
//   Sits at the memory end of the single-cycle core's load/store bus.
//   Provides a word RAM (combinational read, clocked write) and a small
//   TOHOST/STATUS register window. It also keeps a log of every accepted
//   store, which a consumer drains through a valid/ready port.
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   reset       in   synchronous, active-high
//   MemWrite    in   store strobe from the core
//   DataAdr     in   byte address from the core
//   WriteData   in   store data from the core
//   ReadData    out  load data to the core (combinational)
//   log_valid   out  store-log head is valid
//   log_ready   in   consumer accepts the head
//   log_addr    out  head entry address
//   log_data    out  head entry data
//   done        out  TOHOST has been written since reset
//   exit_code   out  last value written to TOHOST
//   overflow    out  sticky: a log push was dropped because the log was full
//   misaligned  out  sticky: a store arrived with DataAdr[1:0] != 0

module dmem_responder #(
    parameter int          MEM_WORDS = 64,
    parameter int          LOG_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        done,
    output logic [31:0] exit_code,
    output logic        overflow,
    output logic        misaligned
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(LOG_DEPTH);

    localparam logic [31:0] STATUS_ADR = MMIO_BASE + 32'd4;
    localparam logic [31:0] RAM_BYTES  = 32'(MEM_WORDS * 4);
    localparam logic [PW-1:0] PTR_ONE  = 1;
    localparam logic [PW:0]   CNT_ONE  = 1;

    // Storage
    logic [31:0]   r_mem      [MEM_WORDS];
    logic [31:0]   r_log_addr [LOG_DEPTH];
    logic [31:0]   r_log_data [LOG_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          r_done;
    logic [31:0]   r_exit_code;
    logic          r_overflow;
    logic          r_misaligned;

    // Decode. The word-aligned address is used so that loads ignore the
    // byte offset; stores only act when the offset is zero anyway.
    logic [31:0]   w_adr_al;
    logic          w_aligned;
    logic          w_ram_hit;
    logic          w_tohost_hit;
    logic          w_status_hit;
    logic [AW-1:0] w_idx;
    logic          w_accept;
    logic          w_full;
    logic          w_pop;
    logic          w_push_ok;
    logic          w_drop;
    logic [7:0]    w_cnt8;

    assign w_adr_al     = {DataAdr[31:2], 2'b00};
    assign w_aligned    = (DataAdr[1:0] == 2'b00);
    assign w_ram_hit    = (w_adr_al < RAM_BYTES);
    assign w_tohost_hit = (w_adr_al == MMIO_BASE);
    assign w_status_hit = (w_adr_al == STATUS_ADR);
    assign w_idx        = DataAdr[AW+1:2];

    // Stores to STATUS or unmapped space are silently ignored.
    assign w_accept = MemWrite & w_aligned & (w_ram_hit | w_tohost_hit) & ~reset;

    assign w_full    = (32'(r_count) == 32'(LOG_DEPTH));
    assign w_pop     = log_valid & log_ready;
    // A pop in the same edge frees the head slot, so a push into a full log
    // still fits; only a push into a full log without a pop is dropped.
    assign w_push_ok = w_accept & (~w_full | w_pop);
    assign w_drop    = w_accept & w_full & ~w_pop;

    assign w_cnt8 = 8'(r_count);

    // Outputs
    assign log_valid  = (r_count != '0);
    assign log_addr   = r_log_addr[r_rd_ptr];
    assign log_data   = r_log_data[r_rd_ptr];
    assign done       = r_done;
    assign exit_code  = r_exit_code;
    assign overflow   = r_overflow;
    assign misaligned = r_misaligned;

    always_comb begin
        ReadData = 32'h0;
        if (w_ram_hit) begin
            ReadData = r_mem[w_idx];
        end else if (w_tohost_hit) begin
            ReadData = r_exit_code;
        end else if (w_status_hit) begin
            ReadData = {16'b0, w_cnt8, 5'b0, log_valid, r_overflow, r_done};
        end
    end

    // RAM is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_accept && w_ram_hit) begin
            r_mem[w_idx] <= WriteData;
        end
    end

    // Log storage: when full with a simultaneous pop, the write pointer
    // equals the read pointer; the head is consumed this edge, so the
    // overwrite is safe.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_log_addr[r_wr_ptr] <= DataAdr;
            r_log_data[r_wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done       <= 1'b0;
            r_exit_code  <= 32'h0;
            r_overflow   <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_accept && w_tohost_hit) begin
                r_done      <= 1'b1;
                r_exit_code <= WriteData;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (MemWrite && !w_aligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam logic [31:0] MMIO = 32'h0000_0400;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        done;
    logic [31:0] exit_code;
    logic        overflow;
    logic        misaligned;

    dmem_responder #(.MEM_WORDS(64), .LOG_DEPTH(8), .MMIO_BASE(MMIO)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .log_valid(log_valid),
        .log_ready(log_ready), .log_addr(log_addr), .log_data(log_data),
        .done(done), .exit_code(exit_code), .overflow(overflow),
        .misaligned(misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model
    logic [31:0] mem_m   [64];
    bit          known_m [64];
    logic [63:0] logq    [$];
    bit          done_m, ovf_m, mis_m;
    logic [31:0] exit_m;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit pop, acc;
        if (reset) begin
            logq.delete();
            done_m = 0; ovf_m = 0; mis_m = 0; exit_m = 32'h0;
        end else begin
            pop = (logq.size() != 0) && log_ready;
            acc = MemWrite && (DataAdr[1:0] == 2'b00) && (DataAdr < 256 || DataAdr == MMIO);
            if (MemWrite && DataAdr[1:0] != 2'b00) mis_m = 1;
            if (acc && DataAdr < 256) begin
                mem_m[DataAdr / 4] = WriteData;
                known_m[DataAdr / 4] = 1;
            end
            if (acc && DataAdr == MMIO) begin
                done_m = 1;
                exit_m = WriteData;
            end
            if (pop) void'(logq.pop_front());
            if (acc) begin
                if (logq.size() < 8) logq.push_back({DataAdr, WriteData});
                else ovf_m = 1;
            end
        end
    endtask

    // Single compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] a;
            logic [63:0] h;
            a = DataAdr & ~32'h3;
            if (a < 256) begin
                if (known_m[a / 4]) check("rdata_ram", ReadData, mem_m[a / 4]);
            end else if (a == MMIO) begin
                check("rdata_tohost", ReadData, exit_m);
            end else if (a == MMIO + 4) begin
                check("rdata_status", ReadData,
                      {16'b0, 8'(logq.size()), 5'b0, logq.size() != 0, ovf_m, done_m});
            end else begin
                check("rdata_unmapped", ReadData, 32'h0);
            end
            check("log_valid", 32'(log_valid), 32'(logq.size() != 0));
            if (logq.size() != 0) begin
                h = logq[0];
                check("log_addr", log_addr, h[63:32]);
                check("log_data", log_data, h[31:0]);
            end
            check("done", 32'(done), 32'(done_m));
            check("exit_code", exit_code, exit_m);
            check("overflow", 32'(overflow), 32'(ovf_m));
            check("misaligned", 32'(misaligned), 32'(mis_m));
        end
    end

    task automatic set_in(input bit rst, input bit we, input logic [31:0] adr,
                          input logic [31:0] wd, input bit rdy);
        reset = rst; MemWrite = we; DataAdr = adr; WriteData = wd; log_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] adr;
        int r;
        for (int i = 0; i < 64; i++) known_m[i] = 0;
        set_in(1, 0, 0, 0, 0);
        tick(); tick();
        chk_en = 1;

        // Basic store and read-after-write
        set_in(0, 1, 100, 25, 0); tick();
        set_in(0, 0, 100, 0, 0); at_sample();
        check("lit_rd100", ReadData, 32'd25);
        check("lit_valid1", 32'(log_valid), 32'd1);
        check("lit_laddr", log_addr, 32'd100);
        check("lit_ldata", log_data, 32'd25);
        check("lit_done0", 32'(done), 32'd0);
        tick();
        set_in(0, 0, 0, 0, 1); tick();

        // Overfill: 9 stores, no drain
        for (int i = 0; i < 9; i++) begin
            set_in(0, 1, 32'(4 * i), 32'(i + 1), 0); tick();
        end
        set_in(0, 0, MMIO + 4, 0, 0); at_sample();
        check("lit_cnt8", 32'(ReadData[15:8]), 32'd8);
        check("lit_ovf1", 32'(overflow), 32'd1);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 0, 1); at_sample();
            check("lit_drain_addr", log_addr, 32'(4 * i));
            check("lit_drain_data", log_data, 32'(i + 1));
            tick();
        end
        set_in(0, 0, 0, 0, 0); at_sample();
        check("lit_empty", 32'(log_valid), 32'd0);
        tick();

        // Full log plus simultaneous push/pop
        set_in(1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 1, 32'(4 * i), 32'(i + 1), 0); tick();
        end
        set_in(0, 1, 36, 99, 1); tick();
        set_in(0, 0, MMIO + 4, 0, 0); at_sample();
        check("lit_full_cnt", 32'(ReadData[15:8]), 32'd8);
        check("lit_full_ovf0", 32'(overflow), 32'd0);
        check("lit_full_head", log_addr, 32'd4);
        tick();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 0, 1); tick();
        end

        // TOHOST / STATUS
        set_in(0, 1, MMIO, 32'hDEAD, 0); tick();
        set_in(0, 0, MMIO + 4, 0, 0); at_sample();
        check("lit_done1", 32'(done), 32'd1);
        check("lit_exit_dead", exit_code, 32'hDEAD);
        check("lit_status_done", 32'(ReadData[0]), 32'd1);
        tick();
        set_in(0, 1, MMIO, 7, 0); tick();
        set_in(0, 0, MMIO, 0, 0); at_sample();
        check("lit_exit7", exit_code, 32'd7);
        check("lit_rd_tohost", ReadData, 32'd7);
        tick();
        set_in(0, 0, 0, 0, 1); tick(); tick();

        // Misaligned and unmapped stores
        set_in(0, 1, 96, 32'h55, 0); tick();
        set_in(0, 0, 0, 0, 1); tick();
        set_in(0, 1, 98, 32'hBAD, 0); tick();
        set_in(0, 0, 96, 0, 0); at_sample();
        check("lit_mis_ram", ReadData, 32'h55);
        check("lit_mis_flag", 32'(misaligned), 32'd1);
        check("lit_mis_nolog", 32'(log_valid), 32'd0);
        tick();
        set_in(0, 1, 32'h8000, 32'h1234, 0); tick();
        set_in(0, 0, 32'h8000, 0, 0); at_sample();
        check("lit_unmapped", ReadData, 32'h0);
        check("lit_unmapped_nolog", 32'(log_valid), 32'd0);
        tick();

        // Reset mid-drain, with a store presented during reset
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 32'(200 + 4 * i), 32'(i), 0); tick();
        end
        set_in(1, 1, 100, 32'h77, 1); tick();
        set_in(0, 0, 100, 0, 0); at_sample();
        check("lit_rst_valid", 32'(log_valid), 32'd0);
        check("lit_rst_done", 32'(done), 32'd0);
        check("lit_rst_exit", exit_code, 32'd0);
        check("lit_rst_mis", 32'(misaligned), 32'd0);
        check("lit_rst_ram", ReadData, 32'd25);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) adr = {24'b0, $urandom_range(0, 63) * 4};
            else if (r < 70) adr = {24'b0, 8'($urandom_range(0, 255))};
            else if (r < 80) adr = MMIO;
            else if (r < 88) adr = MMIO + 4;
            else adr = $urandom & 32'h0000_FFFF;
            set_in($urandom_range(0, 299) == 0, $urandom_range(0, 99) < 55, adr,
                   $urandom, $urandom_range(0, 99) < 40);
            tick();
        end
        set_in(0, 0, 0, 0, 0); tick();
        chk_en = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
